// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte stream to 16-bit instruction memory writer
module instruction_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len;
    logic [7:0]        hi_byte;
    logic [ADDR_W:0]   len_clamped;

    // Requested length saturates at the memory depth so addr never wraps
    always_comb begin
        len_clamped = load_len;
        if (load_len > DEPTH_L) begin
            len_clamped = DEPTH_L;
        end
    end

    // Load sequencer; every output is a register updated alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            len        <= '0;
            hi_byte    <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len        <= len_clamped;
                        addr       <= '0;
                        word_count <= '0;
                        if (len_clamped == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= HI;
                            done       <= 1'b0;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            cpu_hold   <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (abort) begin
                        state      <= IDLE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        cpu_hold   <= 1'b0;
                    end else if (byte_valid && byte_ready) begin
                        hi_byte <= byte_data;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (abort) begin
                        state      <= IDLE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        cpu_hold   <= 1'b0;
                    end else if (byte_valid && byte_ready) begin
                        mem_addr   <= addr;
                        mem_wdata  <= DATA_W'({hi_byte, byte_data});
                        mem_we     <= 1'b1;
                        byte_ready <= 1'b0;
                        state      <= WR;
                    end
                end
                WR: begin
                    // The write strobe is already out this cycle, so it always counts
                    word_count <= word_count + ONE_L;
                    if (abort) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else if (word_count + ONE_L == len) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else begin
                        addr       <= addr + 1'b1;
                        byte_ready <= 1'b1;
                        state      <= HI;
                    end
                end
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                    cpu_hold   <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - scoreboard bench for instruction_loader
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  load_len = '0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [4:0]  word_count;

    instruction_loader dut (
        .clk(clk), .rst(rst), .start(start), .load_len(load_len), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [19:0] exp_q[$];
    logic [7:0]  src[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected {addr,data}
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            check("wr_ready_low", 32'(byte_ready), 32'd0);
            check("wr_hold_high", 32'(cpu_hold), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
            end else begin
                check("write", 32'({mem_addr, mem_wdata}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Reference: word i of a load is bytes 2i (high) and 2i+1 (low), at address i
    task automatic model_push(input int nwords);
        for (int i = 0; i < nwords; i++) begin
            exp_q.push_back({4'(i), src[2*i], src[2*i+1]});
        end
    endtask

    // Runs one load; abort_at/busy_start_at are byte counts (-1 = unused)
    task automatic run_load(input int len, input int gap_max, input int abort_at,
                            input int busy_start_at, output int cycles);
        int n;
        int total;
        int sent;
        int gaps;
        int cyc;
        bit aborted;
        n = (len > 16) ? 16 : len;
        total = 2 * n;
        sent = 0;
        gaps = $urandom_range(0, gap_max);
        cyc = 0;
        aborted = 0;
        if (abort_at >= 0) model_push(abort_at / 2);
        else model_push(n);
        @(negedge clk);
        start = 1'b1;
        load_len = 5'(len);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (sent < total && !aborted) begin
            start = 1'b0;
            if (cyc > 500) begin
                checks++;
                errors++;
                $display("FAIL byte_timeout: got %0d bytes expected %0d", sent, total);
                break;
            end
            if (abort_at >= 0 && sent == abort_at) begin
                byte_valid = 1'b0;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                aborted = 1;
                cyc++;
            end else begin
                if (busy_start_at >= 0 && sent == busy_start_at) begin
                    start = 1'b1;
                    load_len = 5'd1;
                    busy_start_at = -1;
                end
                if (gaps > 0) begin
                    byte_valid = 1'b0;
                    byte_data = 8'($urandom);
                    gaps--;
                end else begin
                    byte_valid = 1'b1;
                    byte_data = src[sent];
                    if (byte_ready) begin
                        sent++;
                        gaps = $urandom_range(0, gap_max);
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        byte_valid = 1'b0;
        if (!aborted) begin
            for (int k = 0; k < 20 && !done; k++) begin
                @(negedge clk);
                cyc++;
            end
        end
        cycles = cyc;
    endtask

    task automatic end_checks(input string tag, input int exp_done, input int exp_wc);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_word_count"}, 32'(word_count), 32'(exp_wc));
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        int ln;
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, word_count}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed two-word load with valid held high
        src[0] = 8'h70; src[1] = 8'h16; src[2] = 8'h65; src[3] = 8'h16;
        run_load(2, 0, -1, -1, cyc);
        check("t1_cycles", 32'(cyc), 32'd7);
        end_checks("t1", 1, 2);

        // Full-depth load
        for (int i = 0; i < 32; i++) src[i] = 8'(i);
        run_load(16, 0, -1, -1, cyc);
        end_checks("t2", 1, 16);

        // Zero length then an over-long request
        run_load(0, 0, -1, -1, cyc);
        end_checks("t3a", 1, 0);
        for (int i = 0; i < 32; i++) src[i] = 8'($urandom);
        run_load(20, 1, -1, -1, cyc);
        end_checks("t3b", 1, 16);

        // Random gaps on byte_valid
        for (int i = 0; i < 6; i++) src[i] = 8'($urandom);
        run_load(3, 5, -1, -1, cyc);
        end_checks("t4", 1, 3);

        // Abort after the high byte of word 1, with a start pulsed mid-load
        for (int i = 0; i < 8; i++) src[i] = 8'($urandom);
        run_load(4, 2, 3, 1, cyc);
        end_checks("t5", 0, 1);

        // Random length loads
        for (int t = 0; t < 4; t++) begin
            ln = $urandom_range(1, 20);
            for (int i = 0; i < 40; i++) src[i] = 8'($urandom);
            run_load(ln, 3, -1, -1, cyc);
            end_checks("rnd", 1, (ln > 16) ? 16 : ln);
        end

        // Asynchronous reset while the write strobe is up
        src[0] = 8'h11; src[1] = 8'h22;
        exp_q.push_back({4'd0, 8'h11, 8'h22});
        @(negedge clk);
        start = 1'b1;
        load_len = 5'd2;
        @(negedge clk);
        start = 1'b0;
        byte_valid = 1'b1;
        byte_data = src[0];
        @(negedge clk);
        byte_data = src[1];
        @(negedge clk);
        byte_valid = 1'b0;
        check("t6_we_before_rst", 32'(mem_we), 32'd1);
        #2 rst = 1'b1;
        #1 check("t6_rst_outputs", 32'({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, word_count}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("t6_pending", 32'(exp_q.size()), 32'd0);
        src[0] = 8'hAB; src[1] = 8'hCD;
        run_load(1, 0, -1, -1, cyc);
        end_checks("t6b", 1, 1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Writer side of the instruction memory. It takes a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. Each word is written into the 16-entry instruction memory through its write port (mem_we/mem_addr/mem_wdata). While a load is in progress, the block holds the CPU via cpu_hold, and it reports completion on done.

Parameters:
ADDR_W, 4, instruction memory address width
DATA_W, 16, instruction word width (two bytes)
DEPTH, 16, number of instruction words (2**ADDR_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE
load_len  input  ADDR_W+1  number of words to load, sampled on start; 0 means no writes; values above DEPTH clamp to DEPTH
abort  input  1  cancels an active load; takes effect on the next clock edge
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction memory write strobe, one cycle per word
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
cpu_hold  output  1  high while a load is in progress (CPU stalled/held)
busy  output  1  FSM is not in IDLE or DONE
done  output  1  level; high in DONE, cleared on next start or rst
word_count  output  ADDR_W+1  words written in the current/last load

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; internal address, length and high-byte registers cleared.
- States:
  - IDLE: start → if clamped len==0 → DONE, else → HI with addr=0, word_count=0.
  - HI: byte_ready=1; on valid&ready, latch byte_data as bits[15:8] → LO.
  - LO: byte_ready=1; on valid&ready, latch bits[7:0] → WR.
  - WR: byte_ready=0; mem_we=1 for exactly one cycle; mem_addr=addr; mem_wdata={hi,lo}; word_count increments at the end of the cycle. If word_count+1==len → DONE, else addr+1 → HI.
  - DONE: done=1; start behaves as in IDLE and clears done on the same edge.
- Handshake:
  - A byte transfers only on the clk edge where byte_valid and byte_ready are both 1.
  - byte_data is ignored otherwise.
  - byte_ready is a registered-state decode and does not depend combinationally on byte_valid.
- Timing:
  - Latency from the low-byte transfer edge to the mem_we cycle is 1 clock.
  - Maximum throughput is 1 word per 3 cycles.
- mem_addr and mem_wdata are held stable whenever mem_we=0; they hold the last written values.
- cpu_hold=busy: high in HI, LO and WR; low in IDLE and DONE.
- Wrap: addr never exceeds DEPTH-1; a length of DEPTH ends after the write to address DEPTH-1, with no wrap to 0.
- start while busy: ignored.
- abort:
  - From HI, LO or WR, the FSM goes to IDLE on the next edge.
  - A write already in WR in that cycle still completes, because mem_we is asserted that cycle.
  - After abort, no further writes occur and done stays 0. A half-received word is discarded.
  - word_count keeps the number of completed writes.
- abort and start in the same cycle: abort wins when busy; start wins when idle.
- Reset mid-load: the FSM returns to IDLE immediately (async) and mem_we drops at once.

Test Plan:
- rst, then start with load_len=2 and bytes 0x70,0x16,0x65,0x16 with valid held high → mem_we pulses at addr 0 with data 0x7016, then at addr 1 with data 0x6516. Then done=1, word_count=2, cpu_hold=0, and total cycles from start equal 6 plus 1 to reach DONE.
- load_len=16 with bytes 0x00..0x1F → 16 writes to addr 0..15 with data 0x0001, 0x0203, … 0x1E1F. No write wraps to addr 0, and word_count=16.
- load_len=0, then load_len=20 → len 0 gives done with no mem_we; len 20 performs exactly 16 writes.
- byte_valid toggled randomly with gaps of 0–5 cycles, load_len=3 → only handshaked bytes are taken, and 3 correct writes occur. byte_ready=0 in every WR cycle.
- abort after the high byte of word 1 (load_len=4) → IDLE with only the addr 0 write done; word_count=1, done=0. A start pulsed while busy earlier has no effect.
- rst asserted asynchronously during WR → mem_we falls without waiting for a clock edge and all outputs read 0. A fresh start with load_len=1 and bytes 0xAB,0xCD writes 0xABCD to addr 0.
